ccip_mmio_responder: RTL and testbench

Responder end of the CCI-P MMIO path: consumes MMIO read/write requests arriving on the Rx c0 channel and returns MMIO read responses on the Tx c2 channel. Holds a small AFU CSR space: DFH, AFU ID, optional statistics counters, and a parameterised bank of read/write scratch registers. Sits on the AFU side, directly behind the registered `sRx`/`sTx` boundary stage, and serves every host CSR access.

---
 rtl/ccip_mmio_responder.sv | 173 +++++++++++++++++
 tb/tb_ccip_mmio_responder.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccip_mmio_responder.sv
// CCI-P MMIO responder: DFH, AFU ID, a scratch bank and, when CCIP_MMIO_STATS_EN is
// defined, read/write request counters. Reads answer two cycles after acceptance.
package ccip_if_pkg;
  typedef logic [27:0] t_ccip_c0_RspMemHdr;

  typedef struct packed {
    logic [15:0] address;
    logic [1:0]  length;
    logic        rsvd0;
    logic [8:0]  tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    logic [511:0]       data;
    logic               rspValid;
    logic               mmioRdValid;
    logic               mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    logic [8:0] tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    logic [63:0]         data;
  } t_if_ccip_c2_Tx;
endpackage

module ccip_mmio_responder
  import ccip_if_pkg::*;
#(
  parameter int unsigned NUM_SCRATCH = 4,
  parameter logic [63:0] DFH_VALUE   = 64'h1000_0000_0000_0000,
  parameter logic [63:0] AFU_ID_L    = 64'h0,
  parameter logic [63:0] AFU_ID_H    = 64'h0
) (
  input  logic                       pClk,
  input  logic                       pck_cp2af_softReset_n,
  input  t_if_ccip_c0_Rx             pck_cp2af_sRx_c0,
  output t_if_ccip_c2_Tx             pck_af2cp_sTx_c2,
  output logic [64*NUM_SCRATCH-1:0]  scratch_q
);
  localparam int unsigned ScratchBase = 5;

  t_ccip_c0_ReqMmioHdr reqHdr;
  logic                rdValid;
  logic                wrValid;
  logic [14:0]         reqQword;
  logic                unusedBits;

  assign reqHdr   = t_ccip_c0_ReqMmioHdr'(pck_cp2af_sRx_c0.hdr);
  assign wrValid  = pck_cp2af_sRx_c0.mmioWrValid;
  // A read colliding with a write is dropped; the write wins.
  assign rdValid  = pck_cp2af_sRx_c0.mmioRdValid & ~wrValid;
  assign reqQword = reqHdr.address[15:1];
  assign unusedBits = ^{pck_cp2af_sRx_c0.data[511:64], pck_cp2af_sRx_c0.rspValid,
                        reqHdr.rsvd0};

  logic [63:0] scratch [NUM_SCRATCH];

  always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
    if (!pck_cp2af_softReset_n) begin
      for (int unsigned i = 0; i < NUM_SCRATCH; i++) scratch[i] <= '0;
    end else if (wrValid) begin
      for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
        if (reqQword == 15'(ScratchBase + i)) begin
          if (reqHdr.length == 2'd1) begin
            scratch[i] <= pck_cp2af_sRx_c0.data[63:0];
          end else if (reqHdr.length == 2'd0) begin
            if (reqHdr.address[0]) scratch[i][63:32] <= pck_cp2af_sRx_c0.data[31:0];
            else                   scratch[i][31:0]  <= pck_cp2af_sRx_c0.data[31:0];
          end
        end
      end
    end
  end

  always_comb begin
    scratch_q = '0;
    for (int unsigned i = 0; i < NUM_SCRATCH; i++) scratch_q[64*i +: 64] = scratch[i];
  end

  logic        s1Valid;
  logic [8:0]  s1Tid;
  logic [14:0] s1Qword;
  logic        s1Half;
  logic        s1Dword;

  always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
    if (!pck_cp2af_softReset_n) begin
      s1Valid <= 1'b0;
      s1Tid   <= '0;
      s1Qword <= '0;
      s1Half  <= 1'b0;
      s1Dword <= 1'b0;
    end else begin
      s1Valid <= rdValid;
      if (rdValid) begin
        s1Tid   <= reqHdr.tid;
        s1Qword <= reqQword;
        s1Half  <= reqHdr.address[0];
        s1Dword <= (reqHdr.length == 2'd0);
      end
    end
  end

  logic [31:0] rdCountSnap;
  logic [31:0] wrCountNow;

`ifdef CCIP_MMIO_STATS_EN
  logic [31:0] rdCount;
  logic [31:0] wrCount;
  logic        wrHitRdCnt;
  logic        wrHitWrCnt;

  assign wrHitRdCnt = wrValid && (reqQword == 15'd3);
  assign wrHitWrCnt = wrValid && (reqQword == 15'd4);
  assign wrCountNow = wrCount;

  always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
    if (!pck_cp2af_softReset_n) begin
      rdCount     <= '0;
      wrCount     <= '0;
      rdCountSnap <= '0;
    end else begin
      if (wrHitRdCnt)                         rdCount <= '0;
      else if (rdValid && rdCount != '1)      rdCount <= rdCount + 32'd1;
      if (wrHitWrCnt)                         wrCount <= '0;
      else if (wrValid && !wrHitRdCnt && wrCount != '1) wrCount <= wrCount + 32'd1;
      // Snapshot so a read of RD_COUNT reports the count before its own increment.
      if (rdValid)                            rdCountSnap <= rdCount;
    end
  end
`else
  assign rdCountSnap = '0;
  assign wrCountNow  = '0;
`endif

  logic [63:0] qwData;
  logic [63:0] rspData;

  always_comb begin
    qwData = '0;
    case (s1Qword)
      15'd0:   qwData = DFH_VALUE;
      15'd1:   qwData = AFU_ID_L;
      15'd2:   qwData = AFU_ID_H;
      15'd3:   qwData = {32'h0, rdCountSnap};
      15'd4:   qwData = {32'h0, wrCountNow};
      default: begin
        for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
          if (s1Qword == 15'(ScratchBase + i)) qwData = scratch[i];
        end
      end
    endcase
    rspData = s1Dword ? {2{s1Half ? qwData[63:32] : qwData[31:0]}} : qwData;
  end

  always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
    if (!pck_cp2af_softReset_n) begin
      pck_af2cp_sTx_c2 <= '0;
    end else begin
      pck_af2cp_sTx_c2.mmioRdValid <= s1Valid;
      if (s1Valid) begin
        pck_af2cp_sTx_c2.hdr.tid <= s1Tid;
        pck_af2cp_sTx_c2.data    <= rspData;
      end
    end
  end
endmodule

// File: tb/tb_ccip_mmio_responder.sv
// Directed bench for ccip_mmio_responder: ID reads, scratch writes, read-after-write,
// collisions, unmapped space, mid-flight reset and build-dependent counters.
module tb_ccip_mmio_responder;
  import ccip_if_pkg::*;

  localparam logic [63:0] Dfh = 64'h1000_0000_0000_0000;
  localparam logic [63:0] IdL = 64'h1111_2222_3333_4444;
  localparam logic [63:0] IdH = 64'h5555_6666_7777_8888;
  localparam int NumScratch = 4;

  logic pClk = 1'b0;
  logic rstN;
  t_if_ccip_c0_Rx c0;
  t_if_ccip_c2_Tx c2;
  logic [64*NumScratch-1:0] scratchQ;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  logic [8:0]  qTid[$];
  logic [63:0] qData[$];
  int          qCyc[$];

  ccip_mmio_responder #(
    .NUM_SCRATCH(NumScratch),
    .DFH_VALUE  (Dfh),
    .AFU_ID_L   (IdL),
    .AFU_ID_H   (IdH)
  ) dut (
    .pClk                 (pClk),
    .pck_cp2af_softReset_n(rstN),
    .pck_cp2af_sRx_c0     (c0),
    .pck_af2cp_sTx_c2     (c2),
    .scratch_q            (scratchQ)
  );

  always #5 pClk = ~pClk;
  always @(posedge pClk) cyc++;
  always @(negedge pClk) begin
    if (c2.mmioRdValid === 1'b1) begin
      qTid.push_back(c2.hdr.tid);
      qData.push_back(c2.data);
      qCyc.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge pClk);
    #1;
  endtask

  task automatic clearQ();
    qTid.delete();
    qData.delete();
    qCyc.delete();
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [1:0] len, input logic [8:0] tid, input logic [63:0] data);
    t_ccip_c0_ReqMmioHdr h;
    h = '0;
    h.address = addr;
    h.length = len;
    h.tid = tid;
    c0 = '0;
    c0.hdr = t_ccip_c0_RspMemHdr'(h);
    c0.data = 512'(data);
    c0.mmioRdValid = rd;
    c0.mmioWrValid = wr;
    tick(1);
    c0 = '0;
  endtask

  // Issues one read and waits (bounded) for its response; lat is cycles from issue.
  task automatic readOnce(input logic [15:0] addr, input logic [1:0] len, input logic [8:0] tid,
                          output bit got, output logic [63:0] data, output logic [8:0] rtid,
                          output int lat);
    int t0;
    clearQ();
    t0 = cyc;
    drive(1'b1, 1'b0, addr, len, tid, 64'h0);
    for (int i = 0; i < 8 && qData.size() == 0; i++) tick(1);
    got = (qData.size() != 0);
    data = got ? qData[0] : 64'h0;
    rtid = got ? qTid[0] : 9'h0;
    lat = got ? qCyc[0] - t0 : -1;
  endtask

  task automatic doReset();
    rstN = 1'b0;
    c0 = '0;
    tick(2);
    rstN = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    c0 = '0;
    tick(2);
    checks++;
    if (c2.mmioRdValid !== 1'b0) begin
      failures++; $display("FAIL reset_valid: got=%b want=0", c2.mmioRdValid);
    end
    checks++;
    if (c2.hdr.tid !== 9'h0) begin
      failures++; $display("FAIL reset_tid: got=%h want=0", c2.hdr.tid);
    end
    checks++;
    if (c2.data !== 64'h0) begin
      failures++; $display("FAIL reset_data: got=%h want=0", c2.data);
    end
    checks++;
    if (scratchQ !== '0) begin
      failures++; $display("FAIL reset_scratch: got=%h want=0", scratchQ);
    end
    rstN = 1'b1;
    tick(1);
  endtask

  task automatic test_id_reads();
    logic [63:0] expData[3];
    int t0;
    bit got;
    logic [63:0] d;
    logic [8:0] t;
    int lat;
    expData[0] = Dfh;
    expData[1] = IdL;
    expData[2] = IdH;
    clearQ();
    t0 = cyc;
    drive(1'b1, 1'b0, 16'h0000, 2'd1, 9'd1, 64'h0);
    drive(1'b1, 1'b0, 16'h0002, 2'd1, 9'd2, 64'h0);
    drive(1'b1, 1'b0, 16'h0004, 2'd1, 9'd3, 64'h0);
    tick(4);
    checks++;
    if (qData.size() != 3) begin
      failures++; $display("FAIL id_count: got=%0d want=3", qData.size());
    end
    for (int k = 0; k < 3; k++) begin
      if (qData.size() > k) begin
        checks++;
        if (qTid[k] !== 9'(k + 1) || qData[k] !== expData[k] || qCyc[k] != t0 + 2 + k) begin
          failures++;
          $display("FAIL id_read%0d: tid=%0d data=%h cyc=%0d want tid=%0d data=%h cyc=%0d",
                   k, qTid[k], qData[k], qCyc[k], k + 1, expData[k], t0 + 2 + k);
        end
      end
    end
    readOnce(16'h0003, 2'd0, 9'd4, got, d, t, lat);
    checks++;
    if (!got || d !== 64'h1111_2222_1111_2222 || t !== 9'd4) begin
      failures++; $display("FAIL id_dw_read: got=%b data=%h tid=%0d want data=1111222211112222 tid=4",
                           got, d, t);
    end
  endtask

  task automatic test_scratch();
    bit got;
    logic [63:0] d;
    logic [8:0] t;
    int lat;
    logic [64*NumScratch-1:0] expQ;
    drive(1'b0, 1'b1, 16'h000A, 2'd1, 9'd0, 64'hDEAD_BEEF_0123_4567);
    drive(1'b0, 1'b1, 16'h000B, 2'd0, 9'd0, 64'h5A5A_5A5A_CAFE_F00D);
    readOnce(16'h000A, 2'd1, 9'd5, got, d, t, lat);
    checks++;
    if (!got || d !== 64'hCAFE_F00D_0123_4567 || t !== 9'd5) begin
      failures++; $display("FAIL scratch_rmw: got=%b data=%h tid=%0d want data=cafef00d01234567 tid=5",
                           got, d, t);
    end
    checks++;
    if (scratchQ[63:0] !== 64'hCAFE_F00D_0123_4567) begin
      failures++; $display("FAIL scratch_q0: got=%h want=cafef00d01234567", scratchQ[63:0]);
    end
    readOnce(16'h000A, 2'd0, 9'd6, got, d, t, lat);
    checks++;
    if (!got || d !== 64'h0123_4567_0123_4567) begin
      failures++; $display("FAIL scratch_dw_lo: got=%b data=%h want=0123456701234567", got, d);
    end
    drive(1'b0, 1'b1, 16'h0010, 2'd1, 9'd0, 64'h0F0F_1E1E_2D2D_3C3C);
    drive(1'b0, 1'b1, 16'h0012, 2'd1, 9'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(1'b0, 1'b1, 16'h0000, 2'd1, 9'd0, 64'h1234);
    drive(1'b0, 1'b1, 16'h000A, 2'd2, 9'd0, 64'h9999_9999_9999_9999);
    tick(1);
    expQ = {64'h0F0F_1E1E_2D2D_3C3C, 64'h0, 64'h0, 64'hCAFE_F00D_0123_4567};
    checks++;
    if (scratchQ !== expQ) begin
      failures++; $display("FAIL scratch_vector: got=%h want=%h", scratchQ, expQ);
    end
    readOnce(16'h0012, 2'd1, 9'd7, got, d, t, lat);
    checks++;
    if (!got || d !== 64'h0) begin
      failures++; $display("FAIL past_last_scratch: got=%b data=%h want=0", got, d);
    end
    readOnce(16'h0000, 2'd1, 9'd8, got, d, t, lat);
    checks++;
    if (!got || d !== Dfh) begin
      failures++; $display("FAIL ro_dfh: got=%b data=%h want=%h", got, d, Dfh);
    end
  endtask

  task automatic test_back_to_back();
    bit got;
    logic [63:0] d;
    logic [8:0] t;
    int lat;
    drive(1'b0, 1'b1, 16'h000A, 2'd1, 9'd0, 64'h0BAD_F00D_1234_5678);
    readOnce(16'h000A, 2'd1, 9'h1A5, got, d, t, lat);
    checks++;
    if (!got || d !== 64'h0BAD_F00D_1234_5678 || t !== 9'h1A5 || lat != 2) begin
      failures++; $display("FAIL raw_next_cycle: got=%b data=%h tid=%h lat=%0d want data=0badf00d12345678 tid=1a5 lat=2",
                           got, d, t, lat);
    end
    readOnce(16'h0200, 2'd1, 9'd9, got, d, t, lat);
    checks++;
    if (!got || d !== 64'h0) begin
      failures++; $display("FAIL unmapped_800: got=%b data=%h want=0", got, d);
    end
  endtask

  task automatic test_collision();
    clearQ();
    drive(1'b1, 1'b1, 16'h000C, 2'd1, 9'd11, 64'h7777_0000_7777_0000);
    tick(5);
    checks++;
    if (qData.size() != 0) begin
      failures++; $display("FAIL collision_resp: got=%0d responses want=0", qData.size());
    end
    checks++;
    if (scratchQ[127:64] !== 64'h7777_0000_7777_0000) begin
      failures++; $display("FAIL collision_write: got=%h want=7777000077770000", scratchQ[127:64]);
    end
  endtask

  task automatic test_reset_midflight();
    bit got;
    logic [63:0] d;
    logic [8:0] t;
    int lat;
    clearQ();
    drive(1'b1, 1'b0, 16'h000A, 2'd1, 9'd12, 64'h0);
    rstN = 1'b0;
    tick(2);
    rstN = 1'b1;
    tick(6);
    checks++;
    if (qData.size() != 0) begin
      failures++; $display("FAIL midflight_drop: got=%0d responses want=0", qData.size());
    end
    checks++;
    if (scratchQ !== '0) begin
      failures++; $display("FAIL midflight_scratch: got=%h want=0", scratchQ);
    end
    readOnce(16'h000A, 2'd1, 9'd13, got, d, t, lat);
    checks++;
    if (!got || d !== 64'h0 || t !== 9'd13) begin
      failures++; $display("FAIL post_reset_read: got=%b data=%h tid=%0d want data=0 tid=13", got, d, t);
    end
  endtask

  task automatic test_stats();
    bit got;
    logic [63:0] d;
    logic [8:0] t;
    int lat;
    doReset();
`ifdef CCIP_MMIO_STATS_EN
    clearQ();
    drive(1'b1, 1'b0, 16'h0000, 2'd1, 9'd20, 64'h0);
    drive(1'b1, 1'b0, 16'h0000, 2'd1, 9'd21, 64'h0);
    drive(1'b1, 1'b0, 16'h0000, 2'd1, 9'd22, 64'h0);
    tick(4);
    readOnce(16'h0006, 2'd1, 9'd23, got, d, t, lat);
    checks++;
    if (!got || d !== 64'd3) begin
      failures++; $display("FAIL rd_count: got=%b data=%h want=3", got, d);
    end
    drive(1'b0, 1'b1, 16'h000A, 2'd1, 9'd0, 64'h1);
    drive(1'b0, 1'b1, 16'h0012, 2'd1, 9'd0, 64'h2);
    readOnce(16'h0008, 2'd1, 9'd24, got, d, t, lat);
    checks++;
    if (!got || d !== 64'd2) begin
      failures++; $display("FAIL wr_count: got=%b data=%h want=2", got, d);
    end
    drive(1'b0, 1'b1, 16'h0008, 2'd1, 9'd0, 64'h0);
    readOnce(16'h0008, 2'd1, 9'd25, got, d, t, lat);
    checks++;
    if (!got || d !== 64'd0) begin
      failures++; $display("FAIL wr_count_clear: got=%b data=%h want=0", got, d);
    end
    drive(1'b0, 1'b1, 16'h0006, 2'd1, 9'd0, 64'h0);
    readOnce(16'h0006, 2'd1, 9'd26, got, d, t, lat);
    checks++;
    if (!got || d !== 64'd0) begin
      failures++; $display("FAIL rd_count_clear: got=%b data=%h want=0", got, d);
    end
    readOnce(16'h0008, 2'd1, 9'd27, got, d, t, lat);
    checks++;
    if (!got || d !== 64'd0) begin
      failures++; $display("FAIL wr_count_nocount: got=%b data=%h want=0", got, d);
    end
`else
    drive(1'b1, 1'b0, 16'h0000, 2'd1, 9'd20, 64'h0);
    drive(1'b0, 1'b1, 16'h000A, 2'd1, 9'd0, 64'h1);
    tick(3);
    readOnce(16'h0006, 2'd1, 9'd23, got, d, t, lat);
    checks++;
    if (!got || d !== 64'd0) begin
      failures++; $display("FAIL rd_count_off: got=%b data=%h want=0", got, d);
    end
    readOnce(16'h0008, 2'd1, 9'd24, got, d, t, lat);
    checks++;
    if (!got || d !== 64'd0) begin
      failures++; $display("FAIL wr_count_off: got=%b data=%h want=0", got, d);
    end
    drive(1'b0, 1'b1, 16'h0006, 2'd1, 9'd0, 64'hFF);
    readOnce(16'h0006, 2'd1, 9'd25, got, d, t, lat);
    checks++;
    if (!got || d !== 64'd0) begin
      failures++; $display("FAIL rd_count_off_wr: got=%b data=%h want=0", got, d);
    end
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rstN = 1'b0;
    c0 = '0;
    test_reset();
    test_id_reads();
    test_scratch();
    test_back_to_back();
    test_collision();
    test_reset_midflight();
    test_stats();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
